axon_spike_scheduler: RTL and testbench

AXON_SPIKE_SCHEDULER -- requirements
Module: axon_spike_scheduler

---
 rtl/axon_spike_scheduler_pkg.sv | 10 +
 rtl/axon_priority_encoder.sv | 21 ++
 rtl/axon_spike_scheduler.sv | 94 +++++++++
 tb/tb_axon_spike_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axon_spike_scheduler_pkg.sv
// Shared core package: axon-count default and the axon index width derived from it,
// used by the spike scheduler and the core controller that pops from it.
package axon_spike_scheduler_pkg;

  localparam int NUM_AXONS_DEFAULT = 256;
  localparam int AXON_W_DEFAULT    = $clog2(NUM_AXONS_DEFAULT);

  typedef logic [AXON_W_DEFAULT-1:0] axon_idx_t;

endpackage

// File: rtl/axon_priority_encoder.sv
// Combinational lowest-set-bit finder over the pending-axon vector.
module axon_priority_encoder #(
  parameter int N = 256,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scanning downward lets the lowest set index be the last (winning) write.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/axon_spike_scheduler.sv
// Double-banked spike scheduler: packets fill one bank while the controller drains the
// other lowest-index-first; a tick swaps the banks and flags any spikes left undrained.
module axon_spike_scheduler
  import axon_spike_scheduler_pkg::*;
#(
  parameter int  NUM_AXONS = NUM_AXONS_DEFAULT,
  localparam int AXON_W    = $clog2(NUM_AXONS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              packet_valid,
  input  logic [AXON_W-1:0] packet_axon,
  input  logic              read_spike,
  output logic              decoder_empty,
  output logic [AXON_W-1:0] axon_number,
  output logic              axon_number_valid,
  output logic              overrun_error
);

  logic [NUM_AXONS-1:0] bank0_q, bank0_d;
  logic [NUM_AXONS-1:0] bank1_q, bank1_d;
  logic                 bank_sel_q, bank_sel_d;
  logic [AXON_W-1:0]    axon_number_q, axon_number_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic [NUM_AXONS-1:0] fill_bank, drain_bank;
  logic [NUM_AXONS-1:0] fill_slot, drain_left, drain_slot;
  logic [AXON_W-1:0]    drain_idx;
  logic                 drain_any;
  logic                 pop;
  logic                 pkt_ok;

  // bank_sel picks which physical bank is currently being filled.
  assign fill_bank  = bank_sel_q ? bank1_q : bank0_q;
  assign drain_bank = bank_sel_q ? bank0_q : bank1_q;

  axon_priority_encoder #(
    .N (NUM_AXONS),
    .W (AXON_W)
  ) u_prio (
    .vec_i (drain_bank),
    .idx_o (drain_idx),
    .any_o (drain_any)
  );

  assign pop    = read_spike & drain_any;
  assign pkt_ok = packet_valid & ({1'b0, packet_axon} < (AXON_W + 1)'(NUM_AXONS));

  always_comb begin
    fill_slot = fill_bank;
    if (pkt_ok) fill_slot[packet_axon] = 1'b1;

    drain_left = drain_bank;
    if (pop) drain_left[drain_idx] = 1'b0;

    // On tick the old drain becomes the new fill bank and starts out clear.
    drain_slot = tick ? '0 : drain_left;

    bank0_d       = bank_sel_q ? drain_slot : fill_slot;
    bank1_d       = bank_sel_q ? fill_slot  : drain_slot;
    bank_sel_d    = bank_sel_q ^ tick;
    axon_number_d = pop ? drain_idx : axon_number_q;
    valid_d       = pop;
    overrun_d     = overrun_q | (tick & (|drain_left));
  end

  // NOTE: the pending banks are plain flops, not RAM, so they are reset with everything else.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank0_q       <= '0;
      bank1_q       <= '0;
      bank_sel_q    <= 1'b0;
      axon_number_q <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      bank0_q       <= bank0_d;
      bank1_q       <= bank1_d;
      bank_sel_q    <= bank_sel_d;
      axon_number_q <= axon_number_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign decoder_empty     = ~(|drain_bank);
  assign axon_number       = axon_number_q;
  assign axon_number_valid = valid_q;
  assign overrun_error     = overrun_q;

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Bench for axon_spike_scheduler: set-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axon_spike_scheduler;

  localparam int N  = 256;
  localparam int W  = 8;
  localparam int SN = 12;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick = 1'b0, packet_valid = 1'b0, read_spike = 1'b0;
  logic [W-1:0]  packet_axon = '0;
  logic          decoder_empty, axon_number_valid, overrun_error;
  logic [W-1:0]  axon_number;

  logic          s_tick = 1'b0, s_packet_valid = 1'b0, s_read_spike = 1'b0;
  logic [SW-1:0] s_packet_axon = '0;
  logic          s_decoder_empty, s_axon_number_valid, s_overrun_error;
  logic [SW-1:0] s_axon_number;

  always #5 clk = ~clk;

  axon_spike_scheduler #(.NUM_AXONS(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .tick              (tick),
    .packet_valid      (packet_valid),
    .packet_axon       (packet_axon),
    .read_spike        (read_spike),
    .decoder_empty     (decoder_empty),
    .axon_number       (axon_number),
    .axon_number_valid (axon_number_valid),
    .overrun_error     (overrun_error)
  );

  axon_spike_scheduler #(.NUM_AXONS(SN)) dut_small (
    .clk               (clk),
    .rst               (rst),
    .tick              (s_tick),
    .packet_valid      (s_packet_valid),
    .packet_axon       (s_packet_axon),
    .read_spike        (s_read_spike),
    .decoder_empty     (s_decoder_empty),
    .axon_number       (s_axon_number),
    .axon_number_valid (s_axon_number_valid),
    .overrun_error     (s_overrun_error)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending spikes as sets of axon indices.
  bit fill_m[int];
  bit drain_m[int];
  int exp_num   = 0;
  bit exp_valid = 1'b0;
  bit exp_ovr   = 1'b0;
  int k_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_m.delete();
      drain_m.delete();
      exp_num   = 0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (read_spike && drain_m.num() > 0) begin
        void'(drain_m.first(k_m));
        drain_m.delete(k_m);
        exp_num   = k_m;
        exp_valid = 1'b1;
      end
      if (packet_valid && int'(packet_axon) < N) fill_m[int'(packet_axon)] = 1'b1;
      if (tick) begin
        if (drain_m.num() > 0) exp_ovr = 1'b1;
        drain_m = fill_m;
        fill_m.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model decoder_empty", decoder_empty, (drain_m.num() == 0));
      check("model axon_number_valid", axon_number_valid, exp_valid);
      check("model axon_number", axon_number, exp_num);
      check("model overrun_error", overrun_error, exp_ovr);
    end
  end

  task automatic step(input bit t, input bit pv, input int ax, input bit rd);
    tick         = t;
    packet_valid = pv;
    packet_axon  = W'(ax);
    read_spike   = rd;
    @(posedge clk); #1;
    tick         = 1'b0;
    packet_valid = 1'b0;
    read_spike   = 1'b0;
  endtask

  task automatic s_step(input bit t, input bit pv, input int ax, input bit rd);
    s_tick         = t;
    s_packet_valid = pv;
    s_packet_axon  = SW'(ax);
    s_read_spike   = rd;
    @(posedge clk); #1;
    s_tick         = 1'b0;
    s_packet_valid = 1'b0;
    s_read_spike   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 cmp_en = 1'b1;
    #10;
    check("reset decoder_empty", decoder_empty, 1);
    check("reset axon_number_valid", axon_number_valid, 0);
    check("reset axon_number", axon_number, 0);
    check("reset overrun_error", overrun_error, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Three packets, tick, three spaced pops in ascending order.
    step(0, 1, 7, 0);
    step(0, 1, 3, 0);
    step(0, 1, 200, 0);
    check("pre-tick empty", decoder_empty, 1);
    step(1, 0, 0, 0);
    check("post-tick not empty", decoder_empty, 0);
    step(0, 0, 0, 1);
    check("pop1 valid", axon_number_valid, 1);
    check("pop1 num", axon_number, 3);
    step(0, 0, 0, 0);
    check("pop1 pulse one cycle", axon_number_valid, 0);
    step(0, 0, 0, 1);
    check("pop2 num", axon_number, 7);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("pop3 num", axon_number, 200);
    check("pop3 empty", decoder_empty, 1);
    step(0, 0, 0, 0);

    // Duplicate packets merge into one pending spike.
    step(0, 1, 5, 0);
    step(0, 1, 5, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("dup pop num", axon_number, 5);
    check("dup pop valid", axon_number_valid, 1);
    step(0, 0, 0, 1);
    check("dup second read no valid", axon_number_valid, 0);
    check("dup second read holds num", axon_number, 5);

    // Tick with a same-cycle pop; leftover spike is discarded and flagged.
    step(0, 1, 10, 0);
    step(0, 1, 20, 0);
    step(1, 0, 0, 0);
    check("overrun pre", overrun_error, 0);
    step(1, 0, 0, 1);
    check("tick pop num", axon_number, 10);
    check("tick pop valid", axon_number_valid, 1);
    check("overrun set", overrun_error, 1);
    check("discarded empty", decoder_empty, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("overrun sticky", overrun_error, 1);

    // Packet coincident with tick lands in the bank that becomes drain.
    step(1, 1, 9, 0);
    check("coincident not empty", decoder_empty, 0);
    step(0, 0, 0, 1);
    check("coincident pop num", axon_number, 9);

    // Reset asserted while a pop is pending.
    step(0, 1, 4, 0);
    step(1, 0, 0, 0);
    read_spike = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    read_spike = 1'b0;
    rst = 1'b1;
    check("rst abandon valid", axon_number_valid, 0);
    check("rst abandon empty", decoder_empty, 1);
    check("rst abandon overrun", overrun_error, 0);
    step(0, 0, 0, 0);
    check("rst no late pulse", axon_number_valid, 0);

    // Boundary indices.
    step(0, 1, 255, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("boundary pop0", axon_number, 0);
    check("boundary pop0 valid", axon_number_valid, 1);
    step(0, 0, 0, 1);
    check("boundary pop255", axon_number, 255);
    check("boundary empty", decoder_empty, 1);

    // Non-power-of-two instance: out-of-range axons are dropped.
    s_step(0, 1, 13, 0);
    s_step(0, 1, 15, 0);
    s_step(1, 0, 0, 0);
    check("small oob dropped", s_decoder_empty, 1);
    s_step(0, 1, 11, 0);
    s_step(1, 0, 0, 0);
    check("small in-range pending", s_decoder_empty, 0);
    s_step(0, 0, 0, 1);
    check("small pop valid", s_axon_number_valid, 1);
    check("small pop num", s_axon_number, 11);
    check("small empty after", s_decoder_empty, 1);
    check("small overrun", s_overrun_error, 0);

    // Randomized traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 3000; i++) begin
      int ax;
      ax = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, ax, $urandom_range(0, 2) != 0);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
